// File: rtl/neuron_mac_unit.sv
// Single-neuron multiply-accumulate engine: streams len sample/weight pairs,
// adds a bias, then applies a fixed-point ReLU with saturation to DATA_W bits.
module neuron_mac_unit #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int HIDDEN_LEN = 62,
    parameter int OUTPUT_LEN = 30,
    parameter int FRAC       = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_neuron,
    input  logic                     hidden,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [15:0]       bias,
    output logic [5:0]               addr,
    output logic                     busy,
    output logic                     calculation_done,
    output logic signed [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BIAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] HID_LAST = 6'(HIDDEN_LEN - 1);
    localparam logic [5:0] OUT_LAST = 6'(OUTPUT_LEN - 1);
    localparam logic signed [ACC_W:0] POS_MAX = (ACC_W + 1)'((2 ** (DATA_W - 1)) - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [5:0]               r_addr;
    logic [5:0]               r_last;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_result;

    logic                     w_accept;
    logic                     w_mac;
    logic                     w_bias;
    logic                     w_last;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_shift;

    // ReLU folded into saturation: negatives clamp to zero, overflow to max positive.
    function automatic logic signed [DATA_W-1:0] relu_sat(input logic signed [ACC_W:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > POS_MAX) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    assign w_prod     = x_data * w_data;
    assign w_prod_ext = {{(ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    // One guard bit keeps acc + bias exact before the shift.
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W + 1 - 16){bias[15]}}, bias};
    assign w_shift    = w_sum >>> FRAC;
    assign w_last     = (r_addr == r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_neuron) w_state_nxt = MAC;
            MAC:     if (w_last) w_state_nxt = BIAS;
            BIAS:    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept         = 1'b0;
        w_mac            = 1'b0;
        w_bias           = 1'b0;
        busy             = 1'b1;
        calculation_done = 1'b0;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                w_accept = start_neuron;
            end
            MAC:     w_mac = 1'b1;
            BIAS:    w_bias = 1'b1;
            DONE:    calculation_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: accumulator, read index, latched length and activated result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_addr   <= '0;
            r_last   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc  <= '0;
            r_addr <= '0;
            r_last <= hidden ? HID_LAST : OUT_LAST;
        end else if (w_mac) begin
            r_acc  <= r_acc + w_prod_ext;
            r_addr <= w_last ? 6'd0 : r_addr + 6'd1;
        end else if (w_bias) begin
            r_result <= relu_sat(w_shift);
        end
    end

    assign addr   = r_addr;
    assign result = r_result;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit: hand-computed results, latency and reset behaviour.
module tb_neuron_mac_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_neuron;
    logic              hidden;
    logic signed [7:0] x_data;
    logic signed [7:0] w_data;
    logic signed [15:0] bias;
    logic [5:0]        addr;
    logic              busy;
    logic              calculation_done;
    logic signed [7:0] result;

    int checks = 0;
    int errors = 0;

    neuron_mac_unit dut (
        .clk              (clk),
        .rst              (rst),
        .start_neuron     (start_neuron),
        .hidden           (hidden),
        .x_data           (x_data),
        .w_data           (w_data),
        .bias             (bias),
        .addr             (addr),
        .busy             (busy),
        .calculation_done (calculation_done),
        .result           (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 after accept; returns the cycle in which done is seen.
    task automatic wait_done(input int len, output int cyc, output logic addr_ok);
        cyc     = 1;
        addr_ok = 1'b1;
        while (!calculation_done && cyc < 200) begin
            if (cyc <= len && addr !== 6'(cyc - 1)) addr_ok = 1'b0;
            tick();
            cyc++;
        end
    endtask

    int   cyc;
    int   gap;
    int   pulses;
    logic aok;

    initial begin
        rst = 1'b1; start_neuron = 1'b0; hidden = 1'b0;
        x_data = '0; w_data = '0; bias = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(calculation_done), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_result", 32'(result), 0);
        rst = 1'b0;
        tick();
        check("idle_addr", 32'(addr), 0);

        // Scenario 1: 62 * (1*64) = 3968 -> 62
        hidden = 1'b1; x_data = 8'sd1; w_data = 8'sd64; bias = 16'sd0; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        check("s1_busy", 32'(busy), 1);
        wait_done(62, cyc, aok);
        check("s1_latency", 32'(cyc), 64);
        check("s1_addr_sweep", 32'(aok), 1);
        check("s1_result", 32'(result), 62);
        tick();
        check("s1_no_double", 32'(calculation_done), 0);
        check("s1_idle", 32'(busy), 0);

        // Scenario 2: 30 * (-1*100) = -3000 -> ReLU 0
        hidden = 1'b0; x_data = -8'sd1; w_data = 8'sd100; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        check("s2_result_held", 32'(result), 62);
        wait_done(30, cyc, aok);
        check("s2_latency", 32'(cyc), 32);
        check("s2_result", 32'(result), 0);
        tick();

        // Scenario 3: 62*16129 + 32767 = 1032765 -> saturate 127
        hidden = 1'b1; x_data = 8'sd127; w_data = 8'sd127; bias = 16'sd32767; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(62, cyc, aok);
        check("s3_latency", 32'(cyc), 64);
        check("s3_result", 32'(result), 127);
        tick();

        // Scenario 4: start held across two layers
        hidden = 1'b1; x_data = 8'sd1; w_data = 8'sd64; bias = 16'sd0; start_neuron = 1'b1;
        tick();
        wait_done(62, cyc, aok);
        check("s4_first_latency", 32'(cyc), 64);
        check("s4_first_result", 32'(result), 62);
        hidden = 1'b0;
        tick();
        check("s4_gap_done_low", 32'(calculation_done), 0);
        check("s4_gap_idle", 32'(busy), 0);
        gap = 1;
        while (!calculation_done && gap < 200) begin
            tick();
            gap++;
        end
        start_neuron = 1'b0;
        check("s4_pulse_gap", 32'(gap), 33);
        check("s4_second_result", 32'(result), 30);
        tick();
        check("s4_no_double", 32'(calculation_done), 0);

        // Scenario 5: reset in mid-MAC at addr 20
        hidden = 1'b1; x_data = 8'sd2; w_data = 8'sd3; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        repeat (20) tick();
        check("s5_addr_before_rst", 32'(addr), 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_busy", 32'(busy), 0);
        check("s5_addr", 32'(addr), 0);
        check("s5_result", 32'(result), 0);
        check("s5_done", 32'(calculation_done), 0);
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (calculation_done || busy) pulses++;
        end
        check("s5_no_resume", 32'(pulses), 0);
        hidden = 1'b0; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(30, cyc, aok);
        check("s5_restart_latency", 32'(cyc), 32);
        check("s5_restart_result", 32'(result), 2);
        tick();

        // Scenario 6: hidden/start changed after accept; 30*(-12)+1000 = 640 -> 10
        hidden = 1'b0; x_data = 8'sd3; w_data = -8'sd4; bias = 16'sd1000; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0; hidden = 1'b1;
        tick(); tick();
        start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        cyc = 4;
        while (!calculation_done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("s6_latency", 32'(cyc), 32);
        check("s6_result", 32'(result), 10);
        tick();
        check("s6_no_reaccept", 32'(busy), 0);

        // Boundary: s = 1920 - 1921 = -1 -> 0
        hidden = 1'b0; x_data = 8'sd1; w_data = 8'sd64; bias = -16'sd1921; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(30, cyc, aok);
        check("neg1_result", 32'(result), 0);
        tick();

        // Boundary: s = 1920 + 6272 = 8192 -> 128 saturates to 127
        bias = 16'sd6272; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(30, cyc, aok);
        check("sat128_result", 32'(result), 127);
        tick();

        // Boundary: s = 1920 + 6208 = 8128 -> exactly 127
        bias = 16'sd6208; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(30, cyc, aok);
        check("max127_result", 32'(result), 127);
        tick();

        // Boundary: s = 1920 + 6207 = 8127 -> 126
        bias = 16'sd6207; start_neuron = 1'b1;
        tick();
        start_neuron = 1'b0;
        wait_done(30, cyc, aok);
        check("below_max_result", 32'(result), 126);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
